// File: rtl/udp_send_if.sv
// Request, transmit and payload-source signals of the UDP framer.
// master: the side issuing requests and pulling bytes; slave: the framer itself.
interface udp_send_if;
  logic        send_req;
  logic [10:0] payload_len;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic        busy;
  logic [15:0] udp_length;
  logic        tx_enable;
  logic [7:0]  data_out;
  logic        payload_rd;
  logic [7:0]  payload_data;
  logic        done;

  modport master (
    output send_req, payload_len, src_port, dst_port, tx_enable, payload_data,
    input  busy, udp_length, data_out, payload_rd, done
  );

  modport slave (
    input  send_req, payload_len, src_port, dst_port, tx_enable, payload_data,
    output busy, udp_length, data_out, payload_rd, done
  );
endinterface

// File: rtl/udp_send.sv
// Transmit-side UDP framer: latches a request, emits the 8-byte header and
// then streams show-ahead payload bytes, one byte per enabled cycle.
module udp_send #(
  parameter int unsigned MAX_LEN = 1472
) (
  input  logic       clock,
  input  logic       reset,
  udp_send_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

  localparam logic [10:0] MaxLen = 11'(MAX_LEN);

  state_e      state_q, state_d;
  logic [10:0] byte_no_q, byte_no_d;
  logic [10:0] len_q, len_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] udp_length_q, udp_length_d;
  logic        started_q, started_d;
  logic        done_q, done_d;
  logic [10:0] len_clamped;

  assign len_clamped = (bus.payload_len > MaxLen) ? MaxLen : bus.payload_len;

  // Next-state: request latch, byte counting, completion and abort.
  always_comb begin
    state_d      = state_q;
    byte_no_d    = byte_no_q;
    len_d        = len_q;
    src_d        = src_q;
    dst_d        = dst_q;
    udp_length_d = udp_length_q;
    started_d    = started_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.send_req) begin
          len_d        = len_clamped;
          src_d        = bus.src_port;
          dst_d        = bus.dst_port;
          udp_length_d = {5'b0, len_clamped} + 16'd8;
          byte_no_d    = 11'd0;
          started_d    = 1'b0;
          state_d      = StHeader;
        end
      end
      StHeader: begin
        if (bus.tx_enable) begin
          byte_no_d = byte_no_q + 11'd1;
          started_d = 1'b1;
          if (byte_no_q == 11'd7) begin
            if (len_q == 11'd0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StPayload;
            end
          end
        end else if (started_q) begin
          // A gap after the first byte means the IP layer gave up.
          state_d = StIdle;
        end
      end
      StPayload: begin
        if (bus.tx_enable) begin
          byte_no_d = byte_no_q + 11'd1;
          started_d = 1'b1;
          if (byte_no_q == len_q + 11'd7) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (started_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      byte_no_q    <= 11'd0;
      len_q        <= 11'd0;
      src_q        <= 16'h0000;
      dst_q        <= 16'h0000;
      udp_length_q <= 16'h0000;
      started_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_no_q    <= byte_no_d;
      len_q        <= len_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      udp_length_q <= udp_length_d;
      started_q    <= started_d;
      done_q       <= done_d;
    end
  end

  // Zero-latency byte mux and payload read strobe.
  always_comb begin
    bus.data_out   = 8'h00;
    bus.payload_rd = 1'b0;
    unique case (state_q)
      StHeader: begin
        unique case (byte_no_q[2:0])
          3'd0:    bus.data_out = src_q[15:8];
          3'd1:    bus.data_out = src_q[7:0];
          3'd2:    bus.data_out = dst_q[15:8];
          3'd3:    bus.data_out = dst_q[7:0];
          3'd4:    bus.data_out = udp_length_q[15:8];
          3'd5:    bus.data_out = udp_length_q[7:0];
          default: bus.data_out = 8'h00;  // checksum unused
        endcase
      end
      StPayload: begin
        bus.data_out   = bus.payload_data;
        bus.payload_rd = bus.tx_enable;
      end
      default: ;
    endcase
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.udp_length = udp_length_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_udp_send.sv
// Self-checking bench for udp_send: directed table plus randomized packets
// checked against a byte-stream model built from ports, length and payload.
module tb_udp_send;

  logic clock;
  logic reset;

  udp_send_if bus ();

  udp_send #(.MAX_LEN(1472)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Show-ahead payload source: an endless stream indexed by bytes consumed.
  logic [7:0] pay_mem [0:4095];
  int         rd_cnt = 0;
  assign bus.payload_data = pay_mem[rd_cnt[11:0]];
  always @(posedge clock) if (bus.payload_rd) rd_cnt <= rd_cnt + 1;

  int total = 0;
  int bad   = 0;

  logic [15:0] cur_s, cur_d;
  int          cur_len;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [10:0] plen;
    int          pre_gap;
    int          abort_at;
    bit          noise;
    bit          b2b;
    int          exp_ul;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] model_byte(input int k, input int start);
    logic [15:0] ul;
    ul = 16'(cur_len + 8);
    case (k)
      0: return cur_s[15:8];
      1: return cur_s[7:0];
      2: return cur_d[15:8];
      3: return cur_d[7:0];
      4: return ul[15:8];
      5: return ul[7:0];
      6, 7: return 8'h00;
      default: return pay_mem[12'(start + k - 8)];
    endcase
  endfunction

  // Issue a request at the current negedge; return at the following negedge.
  task automatic do_req(input logic [15:0] s, input logic [15:0] d, input logic [10:0] pl);
    bus.send_req    = 1'b1;
    bus.src_port    = s;
    bus.dst_port    = d;
    bus.payload_len = pl;
    bus.tx_enable   = 1'($urandom_range(0, 1));  // ignored while idle
    cur_s   = s;
    cur_d   = d;
    cur_len = (int'(pl) > 1472) ? 1472 : int'(pl);
    #1;
    chk("idle_data", int'(bus.data_out), 0);
    chk("idle_rd", int'(bus.payload_rd), 0);
    @(negedge clock);
    bus.send_req  = 1'b0;
    bus.tx_enable = 1'b0;
    chk("req_busy", int'(bus.busy), 1);
    chk("req_done", int'(bus.done), 0);
    chk("req_udp_len", int'(bus.udp_length), cur_len + 8);
  endtask

  // Stream the current packet; ends at the negedge after the last edge used.
  task automatic do_stream(input int pre_gap, input int abort_at, input bit noise,
                           output bit full);
    int tot, start, k;
    tot   = cur_len + 8;
    start = rd_cnt;
    for (int g = 0; g < pre_gap; g++) begin
      bus.tx_enable = 1'b0;
      #1;
      chk("gap_rd", int'(bus.payload_rd), 0);
      @(negedge clock);
      chk("gap_busy", int'(bus.busy), 1);
    end
    k = 0;
    while (k < tot && !(abort_at > 0 && k == abort_at)) begin
      bus.tx_enable = 1'b1;
      if (noise) begin
        bus.send_req    = 1'($urandom_range(0, 1));
        bus.src_port    = 16'($urandom);
        bus.dst_port    = 16'($urandom);
        bus.payload_len = 11'($urandom);
      end
      #1;
      chk("data_out", int'(bus.data_out), int'(model_byte(k, start)));
      chk("payload_rd", int'(bus.payload_rd), (k >= 8) ? 1 : 0);
      @(negedge clock);
      k++;
    end
    bus.tx_enable = 1'b0;
    bus.send_req  = 1'b0;
    full = (k == tot);
    if (full) begin
      chk("done_pulse", int'(bus.done), 1);
      chk("done_busy", int'(bus.busy), 0);
      chk("rd_count", rd_cnt - start, cur_len);
    end else begin
      chk("abort_pending", int'(bus.busy), 1);
      @(negedge clock);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_rd", rd_cnt - start, (k > 8) ? k - 8 : 0);
    end
  endtask

  initial begin
    bit full;
    for (int i = 0; i < 4096; i++) pay_mem[i] = 8'($urandom);

    vecs[0] = '{16'd1024, 16'hC350, 11'd4, 0, -1, 1'b0, 1'b0, 12};
    vecs[1] = '{16'h1234, 16'h5678, 11'd0, 0, -1, 1'b0, 1'b0, 8};
    vecs[2] = '{16'hABCD, 16'h0044, 11'd1472, 0, -1, 1'b0, 1'b0, 1480};
    vecs[3] = '{16'h0001, 16'hFFFF, 11'd2000, 0, -1, 1'b0, 1'b1, 1480};
    vecs[4] = '{16'd1024, 16'hC350, 11'd4, 5, 10, 1'b0, 1'b0, 12};
    vecs[5] = '{16'h1111, 16'h2222, 11'd6, 2, -1, 1'b1, 1'b0, 14};

    reset           = 1'b1;
    bus.send_req    = 1'b0;
    bus.tx_enable   = 1'b0;
    bus.payload_len = 11'd0;
    bus.src_port    = 16'h0;
    bus.dst_port    = 16'h0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_udp_len", int'(bus.udp_length), 0);
    chk("rst_data", int'(bus.data_out), 0);
    chk("rst_rd", int'(bus.payload_rd), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        pay_mem[12'(rd_cnt + 0)] = 8'h11;
        pay_mem[12'(rd_cnt + 1)] = 8'h22;
        pay_mem[12'(rd_cnt + 2)] = 8'h33;
        pay_mem[12'(rd_cnt + 3)] = 8'h44;
      end
      do_req(vecs[i].src, vecs[i].dst, vecs[i].plen);
      chk("tbl_udp_len", int'(bus.udp_length), vecs[i].exp_ul);
      do_stream(vecs[i].pre_gap, vecs[i].abort_at, vecs[i].noise, full);
      if (full && !vecs[i].b2b) begin
        @(negedge clock);
        chk("done_clear", int'(bus.done), 0);
      end
    end

    // Async reset at payload byte 3.
    do_req(16'h0BAD, 16'h0F00, 11'd8);
    for (int k = 0; k < 11; k++) begin
      bus.tx_enable = 1'b1;
      @(negedge clock);
    end
    bus.tx_enable = 1'b1;
    #1;
    chk("pre_rst_rd", int'(bus.payload_rd), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_udp_len", int'(bus.udp_length), 0);
    chk("mid_rst_data", int'(bus.data_out), 0);
    chk("mid_rst_rd", int'(bus.payload_rd), 0);
    @(negedge clock);
    chk("mid_rst_hold_done", int'(bus.done), 0);
    reset         = 1'b0;
    bus.tx_enable = 1'b0;
    @(negedge clock);
    do_req(16'h4321, 16'h8765, 11'd5);
    do_stream(0, -1, 1'b0, full);
    @(negedge clock);

    // Randomized packets.
    for (int n = 0; n < 24; n++) begin
      logic [10:0] pl;
      int ab, tot;
      bit b2b;
      pl  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1400, 2047))
                                        : 11'($urandom_range(0, 40));
      do_req(16'($urandom), 16'($urandom), pl);
      tot = cur_len + 8;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot - 1) : -1;
      do_stream($urandom_range(0, 3), ab, 1'($urandom_range(0, 1)), full);
      b2b = 1'($urandom_range(0, 1));
      if (!(full && b2b)) begin
        @(negedge clock);
        chk("rnd_done_clear", int'(bus.done), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_send.md
# udp_send

Transmit-side UDP framer for the Ethernet path. It latches a send request carrying the ports and payload length, then supplies the 8-byte UDP header to the IP transmitter one byte per enabled clock. After the header it streams payload bytes pulled from a show-ahead source such as a FIFO. It sits between the payload sources (EP6 I/Q, DHCP, discovery replies) and the IP transmit layer.

## Interface
Parameters:
- MAX_LEN, 1472, largest payload length accepted, in bytes. Values above this are clamped to MAX_LEN.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- send_req  in  1  request to send; sampled only in IDLE.
- payload_len  in  11  payload byte count; sampled with send_req.
- src_port  in  16  UDP source port; sampled with send_req.
- dst_port  in  16  UDP destination port; sampled with send_req.
- busy  out  1  request accepted and packet not yet finished or aborted.
- udp_length  out  16  latched UDP length (payload + 8), consumed by the IP header builder.
- tx_enable  in  1  IP layer requests one UDP byte per high cycle.
- data_out  out  8  current UDP byte; combinational from state, counter and payload_data.
- payload_rd  out  1  payload byte consumed this cycle; acts as FIFO read strobe.
- payload_data  in  8  show-ahead payload byte.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- States:
  - IDLE: waiting for a request.
  - HEADER: header bytes 0..7.
  - PAYLOAD: payload bytes 8..len+7.
- Internal registers:
  - byte_no: 11 bits.
  - started: 1 bit.
  - latched len, src, dst.
- IDLE with send_req=1:
  - Latch len = min(payload_len, MAX_LEN), src_port and dst_port.
  - udp_length <= {5'b0, len} + 16'd8.
  - byte_no <= 0, started <= 0, go to HEADER.
- send_req while busy is ignored. The latched values must not change mid-packet.
- Header byte map for data_out:
  - byte 0 = src[15:8], byte 1 = src[7:0].
  - byte 2 = dst[15:8], byte 3 = dst[7:0].
  - byte 4 = udp_length[15:8], byte 5 = udp_length[7:0].
  - bytes 6 and 7 = 8'h00. The checksum is always zero, which is legal for IPv4.
- Each cycle with tx_enable=1 in HEADER/PAYLOAD: byte_no increments and started <= 1.
- At byte_no = 7 with tx_enable=1: go to PAYLOAD, or go to IDLE if len = 0.
- In PAYLOAD:
  - data_out = payload_data.
  - payload_rd = tx_enable, and is 0 in every other state.
- At byte_no = len+7 with tx_enable=1: go to IDLE and pulse done.
- Abort: tx_enable=0 while started=1 in HEADER/PAYLOAD → IDLE with no done pulse. Any unread payload is the source's responsibility to flush.
- tx_enable=0 while started=0 means waiting for the IP layer: hold state.
- tx_enable in IDLE is ignored. data_out = 8'h00 and payload_rd = 0.

## Timing
- Reset values:
  - state IDLE, busy 0, done 0, udp_length 16'h0000.
  - byte_no 0, started 0.
  - data_out 8'h00, payload_rd 0.
- send_req at edge N: busy=1 and udp_length valid from cycle N+1.
- data_out is valid in the same cycle tx_enable is high (zero latency). Byte k appears on the k-th enabled cycle.
- payload_rd is asserted in the same cycle the byte is used. The source advances on that edge.
- Gaps in tx_enable before the first enabled cycle are allowed. After started=1, any gap is an abort.
- Completion: done=1 for exactly one cycle, the cycle after the final enabled byte. busy=0 in that same cycle.
- send_req in the done cycle is accepted, since the state is IDLE.
- Total enabled cycles per packet = len + 8. The width of byte_no covers len+7 ≤ 1479.
- Async reset mid-packet forces all reset values immediately. No done pulse is generated.

## Test plan
- Normal packet:
  - Stimulus: send_req, src=1024, dst=0xC350, len=4, payload 11,22,33,44, tx_enable held high.
  - Required: data_out = 04 00 C3 50 00 0C 00 00 11 22 33 44; payload_rd high for exactly 4 cycles; done one cycle after the last byte; udp_length = 12.
- Zero length:
  - Stimulus: len=0.
  - Required: 8 header bytes with length field 00 08; payload_rd never asserted; done after byte 7.
- Maximum and clamp:
  - Stimulus: len=1472, then len=2000.
  - Required: udp_length = 1480 in both cases; 1472 payload_rd pulses each.
- Delayed start and abort:
  - Stimulus: tx_enable held low for 5 cycles after send_req, then high for 10 cycles, then low.
  - Required: first byte is 04; abort returns to IDLE with busy=0 and no done.
- Request handling:
  - Stimulus: send_req while busy with different ports.
  - Required: output bytes unchanged.
  - Stimulus: send_req in the done cycle.
  - Required: accepted, busy=1 on the next cycle.
- Reset:
  - Stimulus: async reset asserted at payload byte 3.
  - Required: all outputs take reset values immediately; a new request afterwards produces a correct packet.
